sp_ram_arbiter: RTL and testbench

- Two-requester front end for one single-port data RAM instance (en/addr/wdata/we/be interface, 1-cycle read latency).
- Shares the RAM between port A (core data side) and port B (debug/AXI bridge side) using req/gnt/rvalid handshakes and round-robin arbitration.
- Optionally zero-fills the whole RAM after reset before accepting any request.
- Sits directly between the requesters and the RAM wrapper in the top level.

---
 rtl/sp_ram_arbiter.sv | 158 +++++++++++++++
 tb/tb_sp_ram_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arbiter.sv
// Two-port round-robin front end for a single-port data RAM with 1-cycle read latency.
// Optionally zero-fills the whole RAM after reset before any request is granted.
module sp_ram_arbiter #(
  parameter int RAM_SIZE       = 32768,
  parameter int ADDR_WIDTH     = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  input  logic                    a_req_i,
  output logic                    a_gnt_o,
  output logic                    a_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   a_addr_i,
  input  logic                    a_we_i,
  input  logic [DATA_WIDTH/8-1:0] a_be_i,
  input  logic [DATA_WIDTH-1:0]   a_wdata_i,
  output logic [DATA_WIDTH-1:0]   a_rdata_o,
  input  logic                    b_req_i,
  output logic                    b_gnt_o,
  output logic                    b_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   b_addr_i,
  input  logic                    b_we_i,
  input  logic [DATA_WIDTH/8-1:0] b_be_i,
  input  logic [DATA_WIDTH-1:0]   b_wdata_i,
  output logic [DATA_WIDTH-1:0]   b_rdata_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
  output logic                    init_done_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = ADDR_WIDTH - 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_SIZE / 4 - 1);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? INIT : RUN;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             rr_q;
  logic             a_rvalid_q;
  logic             b_rvalid_q;

  // FSM state register
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= RESET_STATE;
    end else begin
      state <= next_state;
    end
  end

  // zero-fill word counter, advances only while clearing
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
    end else if (state == INIT) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  // round-robin pointer: after a grant, favour the other port
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_q <= 1'b0;
    end else if (a_gnt_o) begin
      rr_q <= 1'b1;
    end else if (b_gnt_o) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_q;
    end
  end

  // response valid follows each grant by one cycle, reads and writes alike
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      a_rvalid_q <= a_gnt_o;
      b_rvalid_q <= b_gnt_o;
    end
  end

  // next state, grants and RAM drive
  always_comb begin
    next_state  = state;
    a_gnt_o     = 1'b0;
    b_gnt_o     = 1'b0;
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    case (state)
      INIT: begin
        ram_en_o   = 1'b1;
        ram_we_o   = 1'b1;
        ram_be_o   = {BE_W{1'b1}};
        ram_addr_o = {cnt, 2'b00};
        if (cnt == CNT_LAST) begin
          next_state = RUN;
        end else begin
          next_state = INIT;
        end
      end
      RUN: begin
        next_state = RUN;
        if (a_req_i && (!b_req_i || !rr_q)) begin
          a_gnt_o = 1'b1;
        end else if (b_req_i) begin
          b_gnt_o = 1'b1;
        end else begin
          a_gnt_o = 1'b0;
          b_gnt_o = 1'b0;
        end
        if (a_gnt_o) begin
          ram_en_o    = 1'b1;
          ram_we_o    = a_we_i;
          ram_be_o    = a_be_i;
          ram_addr_o  = a_addr_i;
          ram_wdata_o = a_wdata_i;
        end else if (b_gnt_o) begin
          ram_en_o    = 1'b1;
          ram_we_o    = b_we_i;
          ram_be_o    = b_be_i;
          ram_addr_o  = b_addr_i;
          ram_wdata_o = b_wdata_i;
        end else begin
          ram_en_o = 1'b0;
        end
      end
      default: begin
        next_state = RESET_STATE;
      end
    endcase
  end

  assign a_rvalid_o  = a_rvalid_q;
  assign b_rvalid_o  = b_rvalid_q;
  assign a_rdata_o   = ram_rdata_i;
  assign b_rdata_o   = ram_rdata_i;
  assign init_done_o = (state == RUN);

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter: zero-fill, round-robin, byte enables, mid-run reset,
// and a second instance built without the post-reset clear.
module tb_sp_ram_arbiter;

  logic clk;
  logic rstn;
  logic rstn1;

  logic        a_req, a_gnt, a_rvalid, a_we, b_req, b_gnt, b_rvalid, b_we;
  logic [14:0] a_addr, b_addr, ram_addr;
  logic [3:0]  a_be, b_be, ram_be;
  logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata, ram_wdata, ram_rdata;
  logic        ram_en, ram_we, init_done;

  logic        c_a_req, c_a_gnt, c_a_rvalid, c_b_gnt, c_b_rvalid, c_ram_en, c_ram_we, c_init_done;
  logic [5:0]  c_a_addr, c_ram_addr;
  logic [3:0]  c_ram_be;
  logic [31:0] c_a_rdata, c_b_rdata, c_ram_wdata, c_ram_rdata;

  int errors;
  int checks;

  sp_ram_arbiter #(.RAM_SIZE(32768), .DATA_WIDTH(32), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rstn_i(rstn),
    .a_req_i(a_req), .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_addr_i(a_addr),
    .a_we_i(a_we), .a_be_i(a_be), .a_wdata_i(a_wdata), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_addr_i(b_addr),
    .b_we_i(b_we), .b_be_i(b_be), .b_wdata_i(b_wdata), .b_rdata_o(b_rdata),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_we_o(ram_we),
    .ram_be_o(ram_be), .ram_rdata_i(ram_rdata), .init_done_o(init_done)
  );

  sp_ram_arbiter #(.RAM_SIZE(64), .DATA_WIDTH(32), .CLEAR_ON_RESET(1'b0)) dut_noclr (
    .clk(clk), .rstn_i(rstn1),
    .a_req_i(c_a_req), .a_gnt_o(c_a_gnt), .a_rvalid_o(c_a_rvalid), .a_addr_i(c_a_addr),
    .a_we_i(1'b0), .a_be_i(4'hF), .a_wdata_i(32'h0), .a_rdata_o(c_a_rdata),
    .b_req_i(1'b0), .b_gnt_o(c_b_gnt), .b_rvalid_o(c_b_rvalid), .b_addr_i(6'h0),
    .b_we_i(1'b0), .b_be_i(4'h0), .b_wdata_i(32'h0), .b_rdata_o(c_b_rdata),
    .ram_en_o(c_ram_en), .ram_addr_o(c_ram_addr), .ram_wdata_o(c_ram_wdata), .ram_we_o(c_ram_we),
    .ram_be_o(c_ram_be), .ram_rdata_i(c_ram_rdata), .init_done_o(c_init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: word addressed, byte enables, 1-cycle read latency; never-written words read as a marker.
  logic [31:0] mem [0:8191];
  logic        written [0:8191];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int k = 0; k < 4; k++) begin
          if (ram_be[k]) mem[ram_addr[14:2]][8*k +: 8] <= ram_wdata[8*k +: 8];
        end
        written[ram_addr[14:2]] <= 1'b1;
      end
      ram_rdata <= (written[ram_addr[14:2]] === 1'b1) ? mem[ram_addr[14:2]]
                                                       : (32'hBAD0_0000 | 32'(ram_addr[14:2]));
    end
  end
  assign c_ram_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Walk the whole zero-fill, comparing the RAM drive each cycle against {cnt,2'b00}.
  task automatic run_init();
    int bad;
    int first_bad;
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < 8192; i++) begin
      if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_be !== 4'hF || ram_wdata !== 32'h0 ||
          ram_addr !== 15'(i * 4) || a_gnt !== 1'b0 || b_gnt !== 1'b0 || init_done !== 1'b0) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      @(negedge clk); #1;
    end
    check("init_bad_cycles", 32'(bad), 32'h0);
    if (bad != 0) $display("  first bad init cycle %0d", first_bad);
    check("init_done_after_8192", {31'h0, init_done}, 32'h1);
  endtask

  typedef struct packed {
    logic        a_req; logic a_we; logic [3:0] a_be; logic [14:0] a_addr; logic [31:0] a_wdata;
    logic        b_req; logic b_we; logic [3:0] b_be; logic [14:0] b_addr; logic [31:0] b_wdata;
    logic        e_agnt; logic e_bgnt; logic [14:0] e_addr; logic e_we; logic [3:0] e_be;
    logic [31:0] e_wdata; logic e_arv; logic e_brv; logic e_chk; logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(
    input logic ar, input logic aw, input logic [3:0] abe, input logic [14:0] aa, input logic [31:0] ad,
    input logic br, input logic bw, input logic [3:0] bbe, input logic [14:0] ba, input logic [31:0] bd,
    input logic eag, input logic ebg, input logic [14:0] ea, input logic ewe, input logic [3:0] ebe,
    input logic [31:0] ewd, input logic earv, input logic ebrv, input logic chk, input logic [31:0] erd);
    vec_t v;
    v = '{ar, aw, abe, aa, ad, br, bw, bbe, ba, bd, eag, ebg, ea, ewe, ebe, ewd, earv, ebrv, chk, erd};
    return v;
  endfunction

  vec_t vecs [13];

  initial begin
    errors = 0;
    checks = 0;
    rstn = 1'b0; rstn1 = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = 15'h0; a_wdata = 32'h0;
    b_req = 1'b0; b_we = 1'b0; b_be = 4'h0; b_addr = 15'h0; b_wdata = 32'h0;
    c_a_req = 1'b0; c_a_addr = 6'h08;

    // Columns: A req/we/be/addr/wdata | B req/we/be/addr/wdata | exp gntA gntB addr we be wdata | rvA rvB chk rdata
    vecs[0]  = mk(1,1,4'hF,15'h010,32'hDEADBEEF, 0,0,4'h0,15'h000,32'h0, 1,0,15'h010,1,4'hF,32'hDEADBEEF, 0,0,0,32'h0);
    vecs[1]  = mk(1,0,4'hF,15'h010,32'h0,        0,0,4'h0,15'h000,32'h0, 1,0,15'h010,0,4'hF,32'h0,        1,0,0,32'h0);
    vecs[2]  = mk(0,0,4'h0,15'h000,32'h0, 1,1,4'h5,15'h102,32'h11223344, 0,1,15'h102,1,4'h5,32'h11223344, 1,0,1,32'hDEADBEEF);
    vecs[3]  = mk(0,0,4'h0,15'h000,32'h0, 1,0,4'hF,15'h102,32'h0,        0,1,15'h102,0,4'hF,32'h0,        0,1,0,32'h0);
    vecs[4]  = mk(0,0,4'h0,15'h000,32'h0, 0,0,4'h0,15'h000,32'h0,        0,0,15'h000,0,4'h0,32'h0,        0,1,1,32'h00220044);
    vecs[5]  = mk(1,0,4'hF,15'h010,32'h0, 1,0,4'hF,15'h102,32'h0,        1,0,15'h010,0,4'hF,32'h0,        0,0,0,32'h0);
    vecs[6]  = mk(1,0,4'hF,15'h010,32'h0, 1,0,4'hF,15'h102,32'h0,        0,1,15'h102,0,4'hF,32'h0,        1,0,1,32'hDEADBEEF);
    vecs[7]  = mk(1,0,4'hF,15'h010,32'h0, 1,0,4'hF,15'h102,32'h0,        1,0,15'h010,0,4'hF,32'h0,        0,1,1,32'h00220044);
    vecs[8]  = mk(1,0,4'hF,15'h010,32'h0, 1,0,4'hF,15'h102,32'h0,        0,1,15'h102,0,4'hF,32'h0,        1,0,1,32'hDEADBEEF);
    vecs[9]  = mk(1,1,4'h3,15'h010,32'hAABBCCDD, 0,0,4'h0,15'h000,32'h0, 1,0,15'h010,1,4'h3,32'hAABBCCDD, 0,1,1,32'h00220044);
    vecs[10] = mk(1,0,4'hF,15'h010,32'h0, 0,0,4'h0,15'h000,32'h0,        1,0,15'h010,0,4'hF,32'h0,        1,0,0,32'h0);
    vecs[11] = mk(0,0,4'h0,15'h000,32'h0, 0,0,4'h0,15'h000,32'h0,        0,0,15'h000,0,4'h0,32'h0,        1,0,1,32'hDEADCCDD);
    vecs[12] = mk(0,0,4'h0,15'h000,32'h0, 0,0,4'h0,15'h000,32'h0,        0,0,15'h000,0,4'h0,32'h0,        0,0,0,32'h0);

    // Instance without clear: RUN straight out of reset, grant in the first cycle.
    @(negedge clk); @(negedge clk); #1;
    check("noclr_init_done_in_reset", {31'h0, c_init_done}, 32'h1);
    check("noclr_rvalid_in_reset", {31'h0, c_a_rvalid}, 32'h0);
    @(negedge clk);
    rstn1 = 1'b1; c_a_req = 1'b1;
    #1;
    check("noclr_first_gnt", {31'h0, c_a_gnt}, 32'h1);
    check("noclr_ram_addr", {26'h0, c_ram_addr}, 32'h08);
    @(negedge clk); #1;
    check("noclr_rvalid", {31'h0, c_a_rvalid}, 32'h1);
    c_a_req = 1'b0;

    // Reset state of the clearing instance, then zero-fill with A held requesting.
    check("rst_init_done", {31'h0, init_done}, 32'h0);
    check("rst_a_rvalid", {31'h0, a_rvalid}, 32'h0);
    a_req = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = 15'h010; a_wdata = 32'hDEADBEEF;
    #1;
    check("rst_a_gnt_held", {31'h0, a_gnt}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    run_init();

    for (int i = 0; i < 13; i++) begin
      a_req = vecs[i].a_req; a_we = vecs[i].a_we; a_be = vecs[i].a_be;
      a_addr = vecs[i].a_addr; a_wdata = vecs[i].a_wdata;
      b_req = vecs[i].b_req; b_we = vecs[i].b_we; b_be = vecs[i].b_be;
      b_addr = vecs[i].b_addr; b_wdata = vecs[i].b_wdata;
      #1;
      check($sformatf("v%0d_a_gnt", i), {31'h0, a_gnt}, {31'h0, vecs[i].e_agnt});
      check($sformatf("v%0d_b_gnt", i), {31'h0, b_gnt}, {31'h0, vecs[i].e_bgnt});
      check($sformatf("v%0d_ram_en", i), {31'h0, ram_en}, {31'h0, vecs[i].e_agnt | vecs[i].e_bgnt});
      check($sformatf("v%0d_ram_addr", i), {17'h0, ram_addr}, {17'h0, vecs[i].e_addr});
      check($sformatf("v%0d_ram_we", i), {31'h0, ram_we}, {31'h0, vecs[i].e_we});
      check($sformatf("v%0d_ram_be", i), {28'h0, ram_be}, {28'h0, vecs[i].e_be});
      check($sformatf("v%0d_ram_wdata", i), ram_wdata, vecs[i].e_wdata);
      check($sformatf("v%0d_a_rvalid", i), {31'h0, a_rvalid}, {31'h0, vecs[i].e_arv});
      check($sformatf("v%0d_b_rvalid", i), {31'h0, b_rvalid}, {31'h0, vecs[i].e_brv});
      if (vecs[i].e_chk && vecs[i].e_arv) check($sformatf("v%0d_a_rdata", i), a_rdata, vecs[i].e_rdata);
      if (vecs[i].e_chk && vecs[i].e_brv) check($sformatf("v%0d_b_rdata", i), b_rdata, vecs[i].e_rdata);
      @(negedge clk); #1;
    end

    // Reset while an A read is in flight: rvalid dropped at once, zero-fill restarts at 0.
    a_req = 1'b1; a_we = 1'b0; a_be = 4'hF; a_addr = 15'h010; a_wdata = 32'h0;
    #1;
    check("mid_a_gnt", {31'h0, a_gnt}, 32'h1);
    @(posedge clk); #1;
    check("mid_a_rvalid_before_rst", {31'h0, a_rvalid}, 32'h1);
    rstn = 1'b0;
    #1;
    check("mid_a_rvalid_in_rst", {31'h0, a_rvalid}, 32'h0);
    check("mid_a_gnt_in_rst", {31'h0, a_gnt}, 32'h0);
    check("mid_init_done_in_rst", {31'h0, init_done}, 32'h0);
    check("mid_ram_addr_in_rst", {17'h0, ram_addr}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    run_init();
    check("post_rst_a_gnt", {31'h0, a_gnt}, 32'h1);
    @(negedge clk); #1;
    a_req = 1'b0;
    check("post_rst_a_rvalid", {31'h0, a_rvalid}, 32'h1);
    check("post_rst_rdata_zero", a_rdata, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
